// File: rtl/tomasulo_add_unit.sv
// Integer add/sub/compare unit for the Tomasulo back end.
// Fixed-latency pipeline feeding a credit-guarded in-order result buffer.
module tomasulo_add_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [1:0]       issue_op,
  input  logic [XLEN-1:0]  src_a,
  input  logic [XLEN-1:0]  src_b,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  output logic             res_valid,
  output logic [TAG_W-1:0] res_tag,
  output logic [XLEN-1:0]  res_data
);

  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_SLT  = 2'b10;
  localparam logic [1:0] OP_SLTU = 2'b11;

  logic [XLEN-1:0] alu_res;
  logic            accept;
  logic            pop;
  logic            wr;

  logic [LATENCY-1:0]            vld_q, vld_d;
  logic [LATENCY-1:0][TAG_W-1:0] ptag_q, ptag_d;
  logic [LATENCY-1:0][XLEN-1:0]  pdat_q, pdat_d;

  logic [BUF_DEPTH-1:0][TAG_W-1:0] btag_q;
  logic [BUF_DEPTH-1:0][XLEN-1:0]  bdat_q;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] used_q, used_d;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    alu_res = '0;
    unique case (issue_op)
      OP_ADD:  alu_res = src_a + src_b;
      OP_SUB:  alu_res = src_a - src_b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      default: alu_res = '0;
    endcase
  end

  // Credits cover in-flight plus buffered, so the buffer cannot overflow.
  assign issue_ready = (used_q < CW'(BUF_DEPTH));
  assign res_valid   = (cnt_q != '0);
  assign res_tag     = btag_q[head_q];
  assign res_data    = bdat_q[head_q];

  assign accept = issue_valid && issue_ready && !flush;
  assign wr     = vld_q[LATENCY-1] && !flush;
  assign pop    = res_valid && cdb_valid && (cdb_tag == res_tag) && !flush;

  always_comb begin
    vld_d     = vld_q;
    ptag_d    = ptag_q;
    pdat_d    = pdat_q;
    vld_d[0]  = accept;
    ptag_d[0] = issue_tag;
    pdat_d[0] = alu_res;
    for (int i = 1; i < int'(LATENCY); i++) begin
      vld_d[i]  = vld_q[i-1];
      ptag_d[i] = ptag_q[i-1];
      pdat_d[i] = pdat_q[i-1];
    end
    if (flush) vld_d = '0;
  end

  always_comb begin
    cnt_d  = cnt_q;
    used_d = used_q;
    head_d = pop ? inc(head_q) : head_q;
    tail_d = wr ? inc(tail_q) : tail_q;
    unique case ({wr, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    unique case ({accept, pop})
      2'b10:   used_d = used_q + 1'b1;
      2'b01:   used_d = used_q - 1'b1;
      default: used_d = used_q;
    endcase
    if (flush) begin
      cnt_d  = '0;
      used_d = '0;
      head_d = '0;
      tail_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q  <= '0;
      ptag_q <= '0;
      pdat_q <= '0;
    end else begin
      vld_q  <= vld_d;
      ptag_q <= ptag_d;
      pdat_q <= pdat_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btag_q <= '0;
      bdat_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      used_q <= '0;
    end else begin
      if (wr) begin
        btag_q[tail_q] <= ptag_q[LATENCY-1];
        bdat_q[tail_q] <= pdat_q[LATENCY-1];
      end
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      used_q <= used_d;
    end
  end

endmodule

// File: tb/tb_tomasulo_add_unit.sv
// Directed bench for tomasulo_add_unit (LATENCY=2, BUF_DEPTH=2).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_tomasulo_add_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        issue_valid;
  logic        issue_ready;
  logic [1:0]  issue_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [3:0]  issue_tag;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic        res_valid;
  logic [3:0]  res_tag;
  logic [31:0] res_data;

  int errors = 0;
  int checks = 0;

  tomasulo_add_unit #(
    .XLEN(32), .TAG_W(4), .LATENCY(2), .BUF_DEPTH(2)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .src_a(src_a), .src_b(src_b),
    .issue_tag(issue_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] t);
    issue_valid = 1'b1;
    issue_op    = op;
    src_a       = a;
    src_b       = b;
    issue_tag   = t;
  endtask

  task automatic ack(input logic [3:0] t);
    cdb_valid = 1'b1;
    cdb_tag   = t;
    step();
    cdb_valid = 1'b0;
  endtask

  // Issue into an empty unit, wait for the result, check it, then retire it.
  task automatic run_op(input string nm, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] t, input logic [31:0] exp);
    chk({nm, "_rdy"}, 32'(issue_ready), 32'd1);
    drive(op, a, b, t);
    step();
    issue_valid = 1'b0;
    step();
    step();
    chk({nm, "_vld"}, 32'(res_valid), 32'd1);
    chk({nm, "_dat"}, res_data, exp);
    chk({nm, "_tag"}, 32'(res_tag), 32'(t));
    ack(t);
    chk({nm, "_pop"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_op = 2'b00;
    src_a = '0; src_b = '0; issue_tag = '0; cdb_valid = 1'b0; cdb_tag = '0;
    #3;
    chk("rst_vld", 32'(res_valid), 32'd0);
    chk("rst_tag", 32'(res_tag), 32'd0);
    chk("rst_dat", res_data, 32'd0);
    chk("rst_rdy", 32'(issue_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // Single ADD: accept at edge 1, visible after edge 3
    drive(2'b00, 32'd5, 32'd7, 4'd3);
    step();
    issue_valid = 1'b0;
    chk("add_e1", 32'(res_valid), 32'd0);
    step();
    chk("add_e2", 32'(res_valid), 32'd0);
    step();
    chk("add_vld", 32'(res_valid), 32'd1);
    chk("add_dat", res_data, 32'd12);
    chk("add_tag", 32'(res_tag), 32'd3);
    cdb_valid = 1'b1;
    cdb_tag   = 4'd2;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_vld", 32'(res_valid), 32'd1);
      chk("hold_dat", res_data, 32'd12);
    end
    cdb_valid = 1'b0;
    ack(4'd3);
    chk("add_pop", 32'(res_valid), 32'd0);

    // Wrap and compare vectors
    run_op("sub_wrap", 2'b01, 32'd0, 32'd1, 4'd4, 32'hFFFF_FFFF);
    run_op("slt_neg", 2'b10, 32'hFFFF_FFFF, 32'd1, 4'd5, 32'd1);
    run_op("sltu_big", 2'b11, 32'hFFFF_FFFF, 32'd1, 4'd6, 32'd0);
    run_op("add_wrap", 2'b00, 32'hFFFF_FFFF, 32'd1, 4'd7, 32'd0);
    run_op("slt_pos", 2'b10, 32'd5, 32'd3, 4'd8, 32'd0);
    run_op("sltu_lt", 2'b11, 32'd3, 32'd5, 4'd9, 32'd1);

    // Backpressure: two back-to-back issues exhaust the credits
    drive(2'b00, 32'd10, 32'd20, 4'd1);
    step();
    drive(2'b01, 32'd100, 32'd1, 4'd2);
    step();
    issue_valid = 1'b0;
    chk("bp_rdy0", 32'(issue_ready), 32'd0);
    step();
    step();
    chk("bp_rdy1", 32'(issue_ready), 32'd0);
    chk("bp_h1_tag", 32'(res_tag), 32'd1);
    chk("bp_h1_dat", res_data, 32'd30);
    ack(4'd1);
    chk("bp_h2_vld", 32'(res_valid), 32'd1);
    chk("bp_h2_tag", 32'(res_tag), 32'd2);
    chk("bp_h2_dat", res_data, 32'd99);
    chk("bp_rdy_ret", 32'(issue_ready), 32'd1);
    ack(4'd2);
    chk("bp_empty", 32'(res_valid), 32'd0);

    // Pop of head coincides with buffer write of the next entry
    drive(2'b00, 32'd1, 32'd1, 4'd1);
    step();
    drive(2'b00, 32'd2, 32'd2, 4'd2);
    step();
    issue_valid = 1'b0;
    step();
    chk("pw_h1_tag", 32'(res_tag), 32'd1);
    ack(4'd1);
    chk("pw_vld", 32'(res_valid), 32'd1);
    chk("pw_tag", 32'(res_tag), 32'd2);
    chk("pw_dat", res_data, 32'd4);
    chk("pw_rdy", 32'(issue_ready), 32'd1);
    drive(2'b01, 32'd9, 32'd4, 4'd3);
    step();
    issue_valid = 1'b0;
    chk("pw_rdy_full", 32'(issue_ready), 32'd0);
    step();
    step();
    chk("pw_head2", 32'(res_tag), 32'd2);
    ack(4'd2);
    chk("pw_t3_tag", 32'(res_tag), 32'd3);
    chk("pw_t3_dat", res_data, 32'd5);
    ack(4'd3);
    chk("pw_empty", 32'(res_valid), 32'd0);

    // Flush: one buffered, one in flight, issue asserted in flush cycle
    drive(2'b00, 32'd40, 32'd2, 4'd1);
    step();
    drive(2'b00, 32'd50, 32'd2, 4'd2);
    step();
    issue_valid = 1'b0;
    step();
    chk("fl_pre_vld", 32'(res_valid), 32'd1);
    flush = 1'b1;
    drive(2'b00, 32'd60, 32'd2, 4'd7);
    step();
    flush = 1'b0;
    issue_valid = 1'b0;
    chk("fl_vld", 32'(res_valid), 32'd0);
    chk("fl_rdy", 32'(issue_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fl_quiet", 32'(res_valid), 32'd0);
    end

    // Flush with an accept that would otherwise be taken
    drive(2'b00, 32'd1, 32'd2, 4'd1);
    step();
    issue_valid = 1'b0;
    step();
    step();
    flush = 1'b1;
    drive(2'b00, 32'd3, 32'd4, 4'd5);
    step();
    flush = 1'b0;
    issue_valid = 1'b0;
    chk("fl2_vld", 32'(res_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fl2_quiet", 32'(res_valid), 32'd0);
    end
    run_op("post_fl", 2'b00, 32'd21, 32'd21, 4'd10, 32'd42);

    // Asynchronous reset between edges with work in flight
    drive(2'b00, 32'd7, 32'd7, 4'd1);
    step();
    drive(2'b00, 32'd8, 32'd8, 4'd2);
    step();
    issue_valid = 1'b0;
    step();
    chk("ar_pre_vld", 32'(res_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_vld", 32'(res_valid), 32'd0);
    chk("ar_rdy", 32'(issue_ready), 32'd1);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ar_quiet", 32'(res_valid), 32'd0);
    end
    run_op("post_ar", 2'b01, 32'd50, 32'd8, 4'd11, 32'd42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
